// File: rtl/charge_pkg.sv
// Shared types and BCD helpers for the charge scheduler and the per-port control FSMs.
package charge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    CHARGE = 2'd2,
    SWITCH = 2'd3
  } state_e;

  localparam logic [7:0] HIDE_BCD = 8'hFF;

  function automatic logic bcd_valid(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Saturates at 00 so a stray decrement of an empty port stays empty.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v == 8'h00) begin
      return 8'h00;
    end else if (v[3:0] == 4'h0) begin
      return {v[7:4] - 4'd1, 4'h9};
    end else begin
      return {v[7:4], v[3:0] - 4'd1};
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first pending port at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int NPORT = 4,
  localparam int PW = $clog2(NPORT)
) (
  input  logic [NPORT-1:0] pending,
  input  logic [PW-1:0]    rr_ptr,
  output logic [PW-1:0]    pick,
  output logic             any_pending
);

  // Scan farthest-first so the nearest pending port is the last one written.
  always_comb begin
    pick        = rr_ptr;
    any_pending = |pending;
    for (int k = NPORT - 1; k >= 0; k--) begin
      if (pending[(int'(rr_ptr) + k) % NPORT]) begin
        pick = PW'((int'(rr_ptr) + k) % NPORT);
      end
    end
  end

endmodule

// File: rtl/charge_scheduler.sv
// Time-slices one charging power stage among NPORT ports, counting down BCD seconds per port.
// Handshake: a request is taken on a CLK edge where req_valid & req_ready; req_ready is combinational.
module charge_scheduler
  import charge_pkg::*;
#(
  parameter int NPORT    = 4,
  parameter int TICK_DIV = 381,
  parameter int SLICE_S  = 5,
  parameter int DEAD_CYC = 4,
  localparam int PW = $clog2(NPORT)
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [PW-1:0]    req_port,
  input  logic [7:0]       req_time,
  output logic             req_ready,
  input  logic             cancel,
  input  logic [PW-1:0]    cancel_port,
  output logic [NPORT-1:0] pwr_en,
  output logic [NPORT-1:0] pending,
  output logic [PW-1:0]    cur_port,
  output logic [7:0]       cur_time,
  output logic             done,
  output logic [PW-1:0]    done_port,
  output state_e           dbg_state
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(SLICE_S + 1);
  localparam int DW = $clog2(DEAD_CYC + 1);

  state_e state, state_nxt;
  logic [7:0]       rem [NPORT];
  logic [TW-1:0]    tick_cnt;
  logic [SW-1:0]    slice_cnt;
  logic [DW-1:0]    dead_cnt;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;
  logic [NPORT-1:0] cur_onehot;
  logic [7:0]       cur_rem;
  logic             tick, cur_cancel, others, slice_hit, finish, req_ok;

  rr_pick #(.NPORT(NPORT)) u_pick (
    .pending     (pending),
    .rr_ptr      (rr_ptr),
    .pick        (pick_idx),
    .any_pending (pick_any)
  );

  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      pending[i] = (rem[i] != 8'h00);
    end
    cur_onehot           = '0;
    cur_onehot[cur_port] = 1'b1;
  end

  assign req_ready  = !pending[req_port];
  assign req_ok     = req_valid && req_ready && bcd_valid(req_time) && (req_time != 8'h00);
  assign cur_rem    = rem[cur_port];
  assign tick       = (state == CHARGE) && (tick_cnt == TW'(TICK_DIV - 1));
  assign cur_cancel = cancel && (cancel_port == cur_port);
  assign others     = |(pending & ~cur_onehot);
  assign slice_hit  = (slice_cnt == SW'(SLICE_S - 1));
  // Completion wins over preemption; a cancel in the same cycle wins over both.
  assign finish     = tick && (cur_rem == 8'h01) && !cur_cancel;
  assign dbg_state  = state;

  always_comb begin
    state_nxt = state;
    pwr_en    = '0;
    cur_time  = HIDE_BCD;
    case (state)
      IDLE: begin
        if (|pending) state_nxt = GRANT;
      end
      GRANT: begin
        state_nxt = pick_any ? CHARGE : IDLE;
      end
      CHARGE: begin
        pwr_en   = (cur_rem != 8'h00) ? cur_onehot : '0;
        cur_time = cur_rem;
        if (cur_cancel || (cur_rem == 8'h00) || finish || (tick && slice_hit && others)) begin
          state_nxt = SWITCH;
        end
      end
      SWITCH: begin
        cur_time = cur_rem;
        if (dead_cnt == DW'(DEAD_CYC - 1)) state_nxt = pick_any ? GRANT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPORT; i++) rem[i] <= 8'h00;
      tick_cnt  <= '0;
      slice_cnt <= '0;
      dead_cnt  <= '0;
      rr_ptr    <= '0;
      cur_port  <= '0;
      done      <= 1'b0;
      done_port <= '0;
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        if (cancel && (cancel_port == PW'(i))) begin
          rem[i] <= 8'h00;
        end else if (req_ok && (req_port == PW'(i))) begin
          rem[i] <= req_time;
        end else if (tick && (cur_port == PW'(i))) begin
          rem[i] <= bcd_dec(rem[i]);
        end
      end

      if (state == GRANT) begin
        tick_cnt  <= '0;
        slice_cnt <= '0;
        if (pick_any) cur_port <= pick_idx;
      end else if (state == CHARGE) begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        if (tick) slice_cnt <= slice_hit ? '0 : slice_cnt + 1'b1;
      end

      dead_cnt <= (state == SWITCH) ? dead_cnt + 1'b1 : '0;

      if ((state == CHARGE) && (state_nxt == SWITCH)) begin
        rr_ptr <= (cur_port == PW'(NPORT - 1)) ? '0 : cur_port + 1'b1;
      end

      done <= finish;
      if (finish) done_port <= cur_port;
    end
  end

endmodule
